// File: rtl/cordic_freq_est.sv
// Frequency estimator fed by a cordic polar stream: wrapped phase differences are
// averaged over 2^LOG2_AVG samples and reported with the block's peak amplitude.
module cordic_freq_est #(
   parameter int AMP_W    = 12,
   parameter int PHI_W    = 11,
   parameter int LOG2_AVG = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [AMP_W-1:0] amp_i,
   input  logic [PHI_W-1:0] phi_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [AMP_W-1:0] thresh_i,
   output logic [PHI_W-1:0] freq_o,
   output logic [AMP_W-1:0] peak_amp_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam int ACC_W = PHI_W + LOG2_AVG;
   localparam int CNT_W = LOG2_AVG + 1;
   localparam int N     = 1 << LOG2_AVG;

   typedef enum logic [1:0] {SEED, ACCUM, EMIT} state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     r_run;
   logic        [PHI_W-1:0]  r_prev;
   logic signed [ACC_W-1:0]  r_acc;
   logic        [CNT_W-1:0]  r_cnt;
   logic        [AMP_W-1:0]  r_peak;

   logic                     w_accept;
   logic                     w_squelch;
   logic                     w_good;
   logic                     w_last;
   logic        [PHI_W-1:0]  w_diff;
   logic signed [ACC_W-1:0]  w_acc_sum;
   logic        [AMP_W-1:0]  w_peak_next;
   logic        [PHI_W-1:0]  w_freq_next;

   // r_run keeps ready_o low until the first edge after reset release.
   assign ready_o     = r_run && (r_state != EMIT);
   assign w_accept    = valid_i && ready_o;
   assign w_squelch   = amp_i < thresh_i;
   assign w_good      = w_accept && !w_squelch;
   assign w_last      = (r_cnt == CNT_W'(N - 1));

   // Modular subtraction in PHI_W bits is exactly the 2*pi wrap.
   assign w_diff      = phi_i - r_prev;
   assign w_acc_sum   = r_acc + {{LOG2_AVG{w_diff[PHI_W-1]}}, w_diff};
   assign w_peak_next = (amp_i > r_peak) ? amp_i : r_peak;
   // Arithmetic right shift by LOG2_AVG (floor) is just dropping the low bits.
   assign w_freq_next = w_acc_sum[LOG2_AVG +: PHI_W];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= SEED;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SEED: begin
            if (w_good) w_state_next = ACCUM;
         end
         ACCUM: begin
            if (w_accept && w_squelch) w_state_next = SEED;
            else if (w_good && w_last) w_state_next = EMIT;
         end
         EMIT: begin
            if (ready_i) w_state_next = ACCUM;
         end
         default: w_state_next = SEED;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_run      <= 1'b0;
         r_prev     <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_peak     <= '0;
         valid_o    <= 1'b0;
         freq_o     <= '0;
         peak_amp_o <= '0;
      end else begin
         r_run <= 1'b1;
         case (r_state)
            SEED: begin
               if (w_good) begin
                  r_prev <= phi_i;
                  r_peak <= w_peak_next;
               end
            end
            ACCUM: begin
               if (w_good) begin
                  r_acc  <= w_acc_sum;
                  r_cnt  <= r_cnt + CNT_W'(1);
                  r_prev <= phi_i;
                  r_peak <= w_peak_next;
                  if (w_last) begin
                     valid_o    <= 1'b1;
                     freq_o     <= w_freq_next;
                     peak_amp_o <= w_peak_next;
                  end
               end
            end
            EMIT: begin
               // prev survives the handshake so the next block continues the stream.
               if (ready_i) begin
                  valid_o <= 1'b0;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_peak  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_freq_est.sv
// Self-checking bench for cordic_freq_est: directed scenarios plus a random run,
// all compared against a sample-list reference model.
module tb_cordic_freq_est;

   localparam int AMP_W    = 12;
   localparam int PHI_W    = 11;
   localparam int LOG2_AVG = 3;
   localparam int N        = 1 << LOG2_AVG;
   localparam int CIRCLE   = 1 << PHI_W;
   localparam int HALF     = CIRCLE / 2;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic [AMP_W-1:0] amp_i = '0;
   logic [PHI_W-1:0] phi_i = '0;
   logic             valid_i = 1'b0;
   logic             ready_o;
   logic [AMP_W-1:0] thresh_i = '0;
   logic [PHI_W-1:0] freq_o;
   logic [AMP_W-1:0] peak_amp_o;
   logic             valid_o;
   logic             ready_i = 1'b1;

   always #5 clk_i = ~clk_i;

   cordic_freq_est #(.AMP_W(AMP_W), .PHI_W(PHI_W), .LOG2_AVG(LOG2_AVG)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .amp_i      (amp_i),
      .phi_i      (phi_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .thresh_i   (thresh_i),
      .freq_o     (freq_o),
      .peak_amp_o (peak_amp_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: phases as integers, differences summed, mean by floor division.
   bit m_run, m_pend, m_prev_ok;
   int m_prev, m_sum, m_cnt, m_peak, m_freq, m_peak_out;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int wrap(input int d);
      int m;
      m = (d + HALF) % CIRCLE;
      if (m < 0) m += CIRCLE;
      return m - HALF;
   endfunction

   function automatic int floor_div(input int s);
      if (s >= 0) return s / N;
      return -((-s + N - 1) / N);
   endfunction

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input bit v, input int amp, input int phi, input bit rdy);
      bit acc;
      int p;
      amp_i   = AMP_W'(amp);
      phi_i   = PHI_W'(phi);
      valid_i = v;
      ready_i = rdy;
      #1;
      chk("ready_o", ready_o, m_run && !m_pend);
      acc = v && m_run && !m_pend;
      p   = int'($signed(phi_i));
      @(posedge clk_i);
      if (m_pend) begin
         if (rdy) begin
            m_pend = 0; m_sum = 0; m_cnt = 0; m_peak = 0;
         end
      end else if (acc) begin
         if (amp < int'(thresh_i)) begin
            m_prev_ok = 0;
         end else begin
            if (m_prev_ok) begin
               m_sum += wrap(p - m_prev);
               m_cnt++;
            end
            m_prev    = p;
            m_prev_ok = 1;
            if (amp > m_peak) m_peak = amp;
            if (m_cnt == N) begin
               m_pend     = 1;
               m_freq     = floor_div(m_sum);
               m_peak_out = m_peak;
            end
         end
      end
      m_run = 1;
      @(negedge clk_i);
      chk("valid_o", valid_o, m_pend);
      if (m_pend) begin
         chk("freq_o", $signed(freq_o), m_freq);
         chk("peak_amp_o", peak_amp_o, m_peak_out);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      #1;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_ready_o", ready_o, 0);
      chk("rst_freq_o", freq_o, 0);
      chk("rst_peak_amp_o", peak_amp_o, 0);
      repeat (cycles) @(negedge clk_i);
      m_run = 0; m_pend = 0; m_prev_ok = 0;
      m_prev = 0; m_sum = 0; m_cnt = 0; m_peak = 0;
      rst_ni = 1'b1;
      step(0, 0, 0, 1);
   endtask

   initial begin
      int ph, amp;
      bit v, rdy;

      thresh_i = 12'd100;
      @(negedge clk_i);
      do_reset(2);

      // Plain ramp of +16.
      for (int k = 0; k < 9; k++) step(1, 500, 16 * k, 1);
      chk("t1_valid", valid_o, 1);
      chk("t1_freq", $signed(freq_o), 16);
      chk("t1_peak", peak_amp_o, 500);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // Wrap-around, both directions.
      do_reset(2);
      for (int k = 0; k < 9; k++) step(1, 400, 960 + 40 * k, 1);
      chk("t2_freq_up", $signed(freq_o), 40);
      step(0, 0, 0, 1);
      do_reset(2);
      for (int k = 0; k < 9; k++) step(1, 400, -880 - 40 * k, 1);
      chk("t2_freq_dn", $signed(freq_o), -40);
      chk("t2_freq_raw", freq_o, 32'h7D8);
      step(0, 0, 0, 1);

      // Floor rounding.
      do_reset(2);
      for (int k = 0; k < 8; k++) step(1, 300, 0, 1);
      step(1, 300, -1, 1);
      chk("t3_floor_neg", $signed(freq_o), -1);
      step(0, 0, 0, 1);
      for (int k = 0; k < 7; k++) step(1, 300, -1, 1);
      step(1, 300, 0, 1);
      chk("t3_floor_pos", $signed(freq_o), 0);
      step(0, 0, 0, 1);

      // Squelch on the 5th sample of a +8 ramp.
      do_reset(2);
      for (int k = 0; k < 11; k++) step(1, (k == 4) ? 50 : 200 + 10 * k, 8 * k, 1);
      chk("t4_freq", $signed(freq_o), 8);
      chk("t4_peak", peak_amp_o, 300);

      // Backpressure, then continuity of prev into the next block.
      for (int k = 0; k < 5; k++) step(1, 4000, 1000, 0);
      chk("t5_freq_held", $signed(freq_o), 8);
      step(0, 0, 0, 1);
      for (int k = 0; k < 8; k++) step(1, 250, 88 + 8 * k, 1);
      chk("t5_cont_freq", $signed(freq_o), 8);
      step(0, 0, 0, 1);

      // Reset mid-block discards partial accumulation.
      do_reset(2);
      for (int k = 0; k < 5; k++) step(1, 600, 100 * k, 1);
      do_reset(2);
      for (int k = 0; k < 9; k++) step(1, 700, 500 + 16 * k, 1);
      chk("t6_freq", $signed(freq_o), 16);
      chk("t6_peak", peak_amp_o, 700);
      step(0, 0, 0, 1);

      // Random traffic with squelch, stalls and occasional phase jumps.
      do_reset(2);
      thresh_i = 12'd200;
      ph = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) thresh_i = AMP_W'($urandom_range(0, 400));
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         amp = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 199)
                                           : $urandom_range(200, 4095);
         if ($urandom_range(0, 49) == 0) ph = $urandom_range(0, CIRCLE - 1);
         else                            ph = ph + $urandom_range(0, 600) - 300;
         step(v, amp, ph, rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
